seg_scan_ctrl: RTL and testbench

Time-multiplexed scan controller for the four-digit seven-segment display. It shares the common `seg`/`dp` bus among the four digit anodes in round-robin order and shows a 16-bit value (normally the low bits of the counter output) as four hex digits. The value is snapshotted once per frame so the digits never tear. It sits in the top level between the counter and the display pins, in place of the constant drive on `seg`/`an`/`dp`.

---
 rtl/seg_scan_if.sv | 30 +++
 rtl/seg_scan_ctrl.sv | 126 ++++++++++++
 tb/tb_seg_scan_ctrl.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/seg_scan_if.sv
// Bus between the scan controller and its surroundings.
// Ports:
//   i_value[15:0]  value to show, nibble k on digit k
//   i_dp[3:0]      decimal point request per digit (1 = lit)
//   i_enable       0 blanks the display
//   i_lz_blank     1 suppresses leading zeros
//   seg[0:6]       segments a..g, active-low
//   an[0:3]        an[k] enables digit k, active-low
//   dp             decimal point, active-low
//   o_frame_done   one-cycle pulse on each new snapshot
interface seg_scan_if;
    logic [15:0] i_value;
    logic [3:0]  i_dp;
    logic        i_enable;
    logic        i_lz_blank;
    logic [0:6]  seg;
    logic [0:3]  an;
    logic        dp;
    logic        o_frame_done;

    modport master (
        output i_value, i_dp, i_enable, i_lz_blank,
        input  seg, an, dp, o_frame_done
    );

    modport slave (
        input  i_value, i_dp, i_enable, i_lz_blank,
        output seg, an, dp, o_frame_done
    );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed four-digit seven-segment scan controller. The display
// value is snapshotted once per frame; each digit slot starts with a short
// all-dark phase so adjacent digits never ghost into each other.
// Ports:
//   clk        rising-edge clock
//   i_reset_n  synchronous active-low reset
//   bus        seg_scan_if slave (value/dp/enable/lz inputs, seg/an/dp/frame outputs)
module seg_scan_ctrl #(
    parameter int unsigned REFRESH_DIV = 100000,
    parameter int unsigned BLANK_CYC   = 4
) (
    input  logic       clk,
    input  logic       i_reset_n,
    seg_scan_if.slave  bus
);

    localparam int unsigned CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYC);

    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_idx;
    logic [15:0]      r_snap;
    logic [0:6]       r_seg;
    logic [0:3]       r_an;
    logic             r_dp;
    logic             r_frame_done;

    logic             w_tick;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [1:0]       w_idx_nxt;
    logic [15:0]      w_snap_nxt;
    logic             w_frame_done_nxt;
    logic [3:0]       w_nib;
    logic             w_lz_zero;
    logic             w_dark;
    logic [0:6]       w_seg_nxt;
    logic [0:3]       w_an_nxt;
    logic             w_dp_nxt;

    // Hex digit to active-low a..g pattern
    function automatic logic [0:6] hex_to_seg(input logic [3:0] nib);
        logic [0:6] s;
        case (nib)
            4'h0: s = 7'b0000001;
            4'h1: s = 7'b1001111;
            4'h2: s = 7'b0010010;
            4'h3: s = 7'b0000110;
            4'h4: s = 7'b1001100;
            4'h5: s = 7'b0100100;
            4'h6: s = 7'b0100000;
            4'h7: s = 7'b0001111;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0000100;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b1100000;
            4'hC: s = 7'b0110001;
            4'hD: s = 7'b1000010;
            4'hE: s = 7'b0110000;
            default: s = 7'b0111000;
        endcase
        return s;
    endfunction

    // Next-state and next-output logic
    always_comb begin
        w_tick           = (r_cnt == CNT_MAX);
        w_cnt_nxt        = w_tick ? '0 : r_cnt + CNT_W'(1);
        w_idx_nxt        = w_tick ? r_idx + 2'd1 : r_idx;
        w_frame_done_nxt = w_tick && (r_idx == 2'd3);
        w_snap_nxt       = w_frame_done_nxt ? bus.i_value : r_snap;

        case (r_idx)
            2'd0:    w_nib = r_snap[3:0];
            2'd1:    w_nib = r_snap[7:4];
            2'd2:    w_nib = r_snap[11:8];
            default: w_nib = r_snap[15:12];
        endcase

        // Current digit and every digit above it are zero; digit 0 always shows
        case (r_idx)
            2'd0:    w_lz_zero = 1'b0;
            2'd1:    w_lz_zero = (r_snap[15:4] == 12'h000);
            2'd2:    w_lz_zero = (r_snap[15:8] == 8'h00);
            default: w_lz_zero = (r_snap[15:12] == 4'h0);
        endcase

        w_dark = (r_cnt < BLANK_END) || !bus.i_enable || (bus.i_lz_blank && w_lz_zero);

        w_seg_nxt = 7'b1111111;
        w_an_nxt  = 4'b1111;
        w_dp_nxt  = 1'b1;
        if (!w_dark) begin
            w_seg_nxt       = hex_to_seg(w_nib);
            w_an_nxt[r_idx] = 1'b0;
            w_dp_nxt        = ~bus.i_dp[r_idx];
        end
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (!i_reset_n) begin
            r_cnt        <= '0;
            r_idx        <= 2'd0;
            r_snap       <= 16'h0000;
            r_seg        <= 7'b1111111;
            r_an         <= 4'b1111;
            r_dp         <= 1'b1;
            r_frame_done <= 1'b0;
        end else begin
            r_cnt        <= w_cnt_nxt;
            r_idx        <= w_idx_nxt;
            r_snap       <= w_snap_nxt;
            r_seg        <= w_seg_nxt;
            r_an         <= w_an_nxt;
            r_dp         <= w_dp_nxt;
            r_frame_done <= w_frame_done_nxt;
        end
    end

    assign bus.seg          = r_seg;
    assign bus.an           = r_an;
    assign bus.dp           = r_dp;
    assign bus.o_frame_done = r_frame_done;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl with REFRESH_DIV=8, BLANK_CYC=2.
// A cycle model feeds a queue of expected outputs that is drained on the
// falling edge; a vector table and hand sequences check fixed patterns.
module tb_seg_scan_ctrl;

    localparam int RD = 8;
    localparam int BC = 2;

    typedef struct packed {
        logic [0:6] seg;
        logic [0:3] an;
        logic       dp;
        logic       fd;
    } out_t;

    typedef struct {
        logic [15:0] val;
        logic        lz;
        logic        en;
        logic [3:0]  dpr;
        int          k;
        logic        lit;
        logic [0:6]  seg;
        logic        dpo;
    } vec_t;

    localparam out_t DARK = '{seg: 7'b1111111, an: 4'b1111, dp: 1'b1, fd: 1'b0};

    logic [0:6] hex_tab [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_errs   = 0;

    seg_scan_if bus ();

    seg_scan_ctrl #(.REFRESH_DIV(RD), .BLANK_CYC(BC)) dut (
        .clk       (clk),
        .i_reset_n (rst_n),
        .bus       (bus.slave)
    );

    always #5 clk = ~clk;

    // ---------------- reference model + scoreboard ----------------
    int          m_cnt  = 0;
    int          m_idx  = 0;
    logic [15:0] m_snap = 16'h0;
    out_t        sb_q [$];

    function automatic out_t exp_out(input logic rst, input int cnt, input int idx,
                                     input logic [15:0] snap, input logic en,
                                     input logic lz, input logic [3:0] dpr);
        out_t        r;
        logic [15:0] sh;
        r = DARK;
        if (rst) return r;
        sh = snap >> (4 * idx);
        if (!(cnt < BC || !en || (lz && idx >= 1 && sh == 16'h0))) begin
            r.an[idx] = 1'b0;
            r.seg     = hex_tab[sh[3:0]];
            r.dp      = ~dpr[idx];
        end
        r.fd = (cnt == RD - 1) && (idx == 3);
        return r;
    endfunction

    always @(posedge clk) begin
        sb_q.push_back(exp_out(!rst_n, m_cnt, m_idx, m_snap, bus.i_enable,
                               bus.i_lz_blank, bus.i_dp));
        if (!rst_n) begin
            m_cnt  <= 0;
            m_idx  <= 0;
            m_snap <= 16'h0;
        end else begin
            m_cnt <= (m_cnt == RD - 1) ? 0 : m_cnt + 1;
            if (m_cnt == RD - 1) begin
                m_idx <= (m_idx + 1) % 4;
                if (m_idx == 3) m_snap <= bus.i_value;
            end
        end
    end

    task automatic check_out(input string nm, input out_t exp);
        out_t got;
        got = {bus.seg, bus.an, bus.dp, bus.o_frame_done};
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got seg=%b an=%b dp=%b fd=%b, required seg=%b an=%b dp=%b fd=%b",
                     nm, got.seg, got.an, got.dp, got.fd, exp.seg, exp.an, exp.dp, exp.fd);
        end
    endtask

    task automatic check_int(input string nm, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errs++;
            $display("FAIL %s: got %0d, required %0d", nm, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            check_out("scoreboard", sb_q.pop_front());
            check_int("one_anode", int'($countones(~bus.an) <= 1), 1);
        end
    end

    // ---------------- helpers ----------------
    function automatic out_t lit(input int k, input logic [0:6] s, input logic d);
        out_t r;
        r       = DARK;
        r.an[k] = 1'b0;
        r.seg   = s;
        r.dp    = d;
        return r;
    endfunction

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Advance to the falling edge right after the next snapshot edge
    task automatic wait_frame();
        int t;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (bus.o_frame_done !== 1'b1 && t < 40);
        if (bus.o_frame_done !== 1'b1) check_int("frame_timeout", 0, 1);
    endtask

    vec_t       vt [22];
    logic [0:6] s1234 [4];
    logic [0:3] ea;
    int         first;

    initial begin
        vt[0]  = '{16'h1234, 1'b0, 1'b1, 4'b0000, 0, 1'b1, 7'b1001100, 1'b1};
        vt[1]  = '{16'h1234, 1'b0, 1'b1, 4'b0000, 1, 1'b1, 7'b0000110, 1'b1};
        vt[2]  = '{16'h1234, 1'b0, 1'b1, 4'b0000, 2, 1'b1, 7'b0010010, 1'b1};
        vt[3]  = '{16'h1234, 1'b0, 1'b1, 4'b0000, 3, 1'b1, 7'b1001111, 1'b1};
        vt[4]  = '{16'hABCD, 1'b0, 1'b1, 4'b0000, 0, 1'b1, 7'b1000010, 1'b1};
        vt[5]  = '{16'hABCD, 1'b0, 1'b1, 4'b0000, 1, 1'b1, 7'b0110001, 1'b1};
        vt[6]  = '{16'hABCD, 1'b0, 1'b1, 4'b0000, 2, 1'b1, 7'b1100000, 1'b1};
        vt[7]  = '{16'hABCD, 1'b0, 1'b1, 4'b0000, 3, 1'b1, 7'b0001000, 1'b1};
        vt[8]  = '{16'h0050, 1'b1, 1'b1, 4'b0000, 3, 1'b0, 7'b1111111, 1'b1};
        vt[9]  = '{16'h0050, 1'b1, 1'b1, 4'b0000, 2, 1'b0, 7'b1111111, 1'b1};
        vt[10] = '{16'h0050, 1'b1, 1'b1, 4'b0000, 1, 1'b1, 7'b0100100, 1'b1};
        vt[11] = '{16'h0050, 1'b1, 1'b1, 4'b0000, 0, 1'b1, 7'b0000001, 1'b1};
        vt[12] = '{16'h0000, 1'b1, 1'b1, 4'b0000, 0, 1'b1, 7'b0000001, 1'b1};
        vt[13] = '{16'h0000, 1'b1, 1'b1, 4'b0000, 1, 1'b0, 7'b1111111, 1'b1};
        vt[14] = '{16'h0F00, 1'b1, 1'b1, 4'b0000, 3, 1'b0, 7'b1111111, 1'b1};
        vt[15] = '{16'h0F00, 1'b1, 1'b1, 4'b0000, 2, 1'b1, 7'b0111000, 1'b1};
        vt[16] = '{16'h0F00, 1'b1, 1'b1, 4'b0000, 1, 1'b1, 7'b0000001, 1'b1};
        vt[17] = '{16'h6789, 1'b0, 1'b1, 4'b0100, 2, 1'b1, 7'b0001111, 1'b0};
        vt[18] = '{16'h6789, 1'b0, 1'b1, 4'b0100, 1, 1'b1, 7'b0000000, 1'b1};
        vt[19] = '{16'hEEEE, 1'b0, 1'b0, 4'b0000, 0, 1'b0, 7'b1111111, 1'b1};
        vt[20] = '{16'hE000, 1'b1, 1'b1, 4'b0000, 3, 1'b1, 7'b0110000, 1'b1};
        vt[21] = '{16'h5555, 1'b0, 1'b1, 4'b1111, 0, 1'b1, 7'b0100100, 1'b0};
        s1234  = '{7'b1001100, 7'b0000110, 7'b0010010, 7'b1001111};

        // Reset: hold 3 cycles, release with 1234 and enable on
        rst_n          = 1'b0;
        bus.i_value    = 16'h1234;
        bus.i_enable   = 1'b1;
        bus.i_lz_blank = 1'b0;
        bus.i_dp       = 4'b0000;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_out("reset_hold", DARK);
        end
        rst_n = 1'b1;
        first = 0;
        for (int n = 1; n <= 40 && first == 0; n++) begin
            @(negedge clk);
            if (n == 1) check_out("first_out_dark", DARK);
            if (n == 4) check_out("digit0_snap0", lit(0, 7'b0000001, 1'b1));
            if (bus.o_frame_done === 1'b1) first = n;
        end
        check_int("first_frame_done", first, 32);
        for (int k = 0; k < 4; k++) begin
            wait_neg((k == 0) ? 5 : 8);
            check_out("frame1_1234", lit(k, s1234[k], 1'b1));
        end

        // Anode scan order over one frame
        wait_frame();
        for (int j = 1; j <= 32; j++) begin
            @(negedge clk);
            ea = 4'b1111;
            if ((j - 1) % RD >= BC) ea[(j - 1) / RD] = 1'b0;
            check_int("an_seq", int'(bus.an), int'(ea));
        end

        // Snapshot stability across a mid-frame value change
        bus.i_value = 16'hABCD;
        wait_frame();
        wait_neg(10);
        bus.i_value = 16'h0F00;
        wait_neg(11);
        check_out("stable_B", lit(2, 7'b1100000, 1'b1));
        wait_neg(8);
        check_out("stable_A", lit(3, 7'b0001000, 1'b1));
        wait_frame();
        wait_neg(5);
        check_out("new_d0", lit(0, 7'b0000001, 1'b1));
        wait_neg(8);
        check_out("new_d1", lit(1, 7'b0000001, 1'b1));
        wait_neg(8);
        check_out("new_d2", lit(2, 7'b0111000, 1'b1));
        wait_neg(8);
        check_out("new_d3", lit(3, 7'b0000001, 1'b1));

        // Enable low for 10 cycles, decimal point on digit 2
        bus.i_dp = 4'b0100;
        wait_frame();
        wait_neg(3);
        bus.i_enable = 1'b0;
        for (int i = 0; i < 10; i++) begin
            wait_neg(1);
            check_out("enable_off", DARK);
        end
        bus.i_enable = 1'b1;
        wait_neg(1);
        check_out("enable_resume", lit(1, 7'b0000001, 1'b1));
        wait_neg(3);
        check_out("dp_dark_phase", DARK);
        wait_neg(4);
        check_out("dp_digit2", lit(2, 7'b0111000, 1'b0));

        // Reset mid-slot at idx=2, cnt=5
        bus.i_value = 16'hABCD;
        wait_frame();
        wait_neg(21);
        rst_n = 1'b0;
        wait_neg(1);
        check_out("reset_mid", DARK);
        rst_n = 1'b1;
        first = 0;
        for (int m = 1; m <= 40; m++) begin
            @(negedge clk);
            if (m == 3) check_out("reset_mid_d0", lit(0, 7'b0000001, 1'b1));
            if (m == 37) check_out("reset_mid_next", lit(0, 7'b1000010, 1'b1));
            if (bus.o_frame_done === 1'b1 && first == 0) first = m;
        end
        check_int("reset_mid_fd", first, 32);

        // Vector table
        for (int i = 0; i < 22; i++) begin
            bus.i_value    = vt[i].val;
            bus.i_lz_blank = vt[i].lz;
            bus.i_enable   = vt[i].en;
            bus.i_dp       = vt[i].dpr;
            wait_frame();
            wait_neg(RD * vt[i].k + 5);
            check_out($sformatf("vec%0d", i), vt[i].lit ? lit(vt[i].k, vt[i].seg, vt[i].dpo) : DARK);
        end

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
